fbuf_write_scheduler: RTL and testbench
=======================================

Name: fbuf_write_scheduler

Overview:
- Owns the single write port of the framebuffer BRAM and shares it between two requesters: a single-pixel write stream from GPU register decode, and an internal rectangle-fill engine.
- The fill engine converts one fill command (x, y, w, h, colour) into row-major BRAM writes.
- Sits between the AXI4-Lite GPU control slave and the framebuffer BRAM.

Parameters:
FBUF_ADDR_WIDTH, 19, framebuffer BRAM address width
FBUF_DATA_WIDTH, 8, pixel width
FB_WIDTH, 640, pixels per line
FB_HEIGHT, 480, lines
COORD_WIDTH, 10, width of x/y/w/h fields

Ports:
s_axi_ctrl_aclk  in  1  sole clock
s_axi_ctrl_aresetn  in  1  asynchronous active-low reset
pix_valid  in  1  pixel write request
pix_ready  out  1  pixel write accepted this cycle
pix_addr  in  FBUF_ADDR_WIDTH  linear pixel address
pix_data  in  FBUF_DATA_WIDTH  pixel value
fill_start  in  1  one-cycle fill command strobe
fill_x  in  COORD_WIDTH  left column
fill_y  in  COORD_WIDTH  top line
fill_w  in  COORD_WIDTH  width in pixels
fill_h  in  COORD_WIDTH  height in lines
fill_color  in  FBUF_DATA_WIDTH  fill value
fill_busy  out  1  fill engine active
fill_done  out  1  one-cycle pulse, fill complete
fill_err  out  1  one-cycle pulse, command rejected
fbuf_en_wr  out  1  BRAM enable
fbuf_wrea  out  1  BRAM write enable
fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address
fbuf_data  out  FBUF_DATA_WIDTH  BRAM write data

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0, fill FSM to IDLE, last_grant = FILL (so the pixel port wins the first conflict).
- Interface: one clock; reset is asynchronous and active-low.
- fbuf_* outputs are registered. A write granted in cycle N appears on fbuf_* in cycle N+1 with fbuf_en_wr = fbuf_wrea = 1 for exactly one cycle. Otherwise both are 0; addr/data hold their last value.
- At most one write per cycle.
- Arbitration is round-robin. If only one requester is pending, it is granted. If both are pending, the one not granted last time wins. last_grant updates only on a grant.
- pix_ready is combinational: pix_valid AND (fill FSM not requesting OR last_grant == FILL). Handshake = pix_valid & pix_ready.
- Accepted pixel with pix_addr >= FB_WIDTH*FB_HEIGHT: consumed (pix_ready = 1), no BRAM write issued.
- Fill FSM states: IDLE, CHECK, RUN.
  - IDLE: on fill_start, latch all fill_* inputs and go to CHECK. fill_busy rises in the next cycle.
  - CHECK (1 cycle): reject if w == 0, h == 0, x + w > FB_WIDTH or y + h > FB_HEIGHT. Sums use COORD_WIDTH+1 bits.
    - Reject: pulse fill_err, return to IDLE, no writes issued.
    - Accept: row_base = y*FB_WIDTH, cur = row_base + x, col = 0, row = 0; go to RUN.
  - RUN: requests a write every cycle.
    - On grant: write (cur, colour) and col++, cur++.
    - When col reaches w-1 and is granted: col = 0, row++, row_base += FB_WIDTH, cur = row_base + FB_WIDTH + x. No multiplier inside RUN.
    - On the grant of the final pixel (row == h-1, col == w-1): go to IDLE. fill_done pulses in the same cycle that this final write appears on fbuf_*. fill_busy falls in that same cycle.
- fill_start while fill_busy (or in CHECK): ignored, no error.
- Uncontended fill latency: w*h writes; first write on fbuf_* 3 cycles after the fill_start cycle.
- Reset mid-fill: immediately aborts. No fill_done, no further writes.

Optional Feature:
- Macro: FBUF_FILL_CLIP_EN.
- Defined: in CHECK, out-of-bounds rectangles are clipped, not rejected.
  - w_eff = min(w, FB_WIDTH − x); h_eff = min(h, FB_HEIGHT − y).
  - fill_err only if w == 0, h == 0, x >= FB_WIDTH or y >= FB_HEIGHT.
- Undefined: reject rules above apply; clipping logic is absent.

Test Plan:
- Reset with pix_valid = 1: all outputs 0. After release, pixel addr 0x00123 data 0x5A → fbuf_addr = 0x00123, fbuf_data = 0x5A, en/wrea high 1 cycle, one cycle after handshake.
- Fill x=10 y=2 w=3 h=2 colour 0xFF, no contention → 6 writes at addresses 1290,1291,1292,1930,1931,1932. fill_done coincides with the 1932 write; fill_busy deasserts in the same cycle.
- Same fill with pix_valid held high (addr 5) → grants alternate PIX, FILL, PIX, FILL…, pixel first. Fill completes in 12 grant cycles; no write lost or duplicated.
- Fill x=630 w=20 (no macro) → fill_err pulse 2 cycles after start, zero BRAM writes. With FBUF_FILL_CLIP_EN: 10 writes per line, no error.
- pix_addr 307200 → accepted, no fbuf_en_wr. fill_start during a busy fill → ignored; the original fill completes unchanged.
- aresetn low for 1 cycle midway through a 640×480 fill → outputs 0 immediately, no fill_done. A new fill after release works normally.

Source files
------------

// File: rtl/fbuf_write_scheduler.sv
// Framebuffer BRAM write-port scheduler. Round-robin between single-pixel writes and a rectangle-fill engine.
// Optional build macro FBUF_FILL_CLIP_EN: clip out-of-bounds fills to the screen instead of rejecting them.
module fbuf_write_scheduler #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8,
    parameter int FB_WIDTH        = 640,
    parameter int FB_HEIGHT       = 480,
    parameter int COORD_WIDTH     = 10
) (
    input  logic                       s_axi_ctrl_aclk,
    input  logic                       s_axi_ctrl_aresetn,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [FBUF_ADDR_WIDTH-1:0] pix_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] pix_data,
    input  logic                       fill_start,
    input  logic [COORD_WIDTH-1:0]     fill_x,
    input  logic [COORD_WIDTH-1:0]     fill_y,
    input  logic [COORD_WIDTH-1:0]     fill_w,
    input  logic [COORD_WIDTH-1:0]     fill_h,
    input  logic [FBUF_DATA_WIDTH-1:0] fill_color,
    output logic                       fill_busy,
    output logic                       fill_done,
    output logic                       fill_err,
    output logic                       fbuf_en_wr,
    output logic                       fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);

    typedef enum logic [1:0] {FILL_IDLE, FILL_CHECK, FILL_RUN} fill_state_t;
    typedef enum logic {GRANT_PIX, GRANT_FILL} grant_t;

    localparam logic [FBUF_ADDR_WIDTH-1:0] PIX_LIMIT   = FBUF_ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT);
    localparam logic [FBUF_ADDR_WIDTH-1:0] LINE_STRIDE = FBUF_ADDR_WIDTH'(FB_WIDTH);
    localparam logic [COORD_WIDTH:0]       X_LIMIT     = (COORD_WIDTH+1)'(FB_WIDTH);
    localparam logic [COORD_WIDTH:0]       Y_LIMIT     = (COORD_WIDTH+1)'(FB_HEIGHT);

    fill_state_t                state_q, state_d;
    grant_t                     last_grant_q;
    logic                       active_q;
    logic [COORD_WIDTH-1:0]     x_q, y_q, w_q, h_q;
    logic [FBUF_DATA_WIDTH-1:0] color_q;
    logic [COORD_WIDTH-1:0]     col_q, row_q, w_last_q, h_last_q;
    logic [FBUF_ADDR_WIDTH-1:0] row_base_q, cur_q;

    logic                       fill_req, pix_grant, fill_grant;
    logic                       last_col, last_row;
    logic                       reject;
    logic [COORD_WIDTH-1:0]     w_eff, h_eff;
    logic [COORD_WIDTH:0]       x_ext, y_ext, x_end, y_end;
    logic [FBUF_ADDR_WIDTH-1:0] x_addr, row_start, next_base;

    // Arbitration: the pixel port yields only when the fill engine is requesting and the pixel port won last.
    assign fill_req   = (state_q == FILL_RUN);
    assign pix_ready  = active_q && pix_valid && (!fill_req || (last_grant_q == GRANT_FILL));
    assign pix_grant  = pix_ready;
    assign fill_grant = fill_req && !pix_grant;
    assign fill_busy  = (state_q != FILL_IDLE);

    assign last_col = (col_q == w_last_q);
    assign last_row = (row_q == h_last_q);

    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};
    assign x_end = x_ext + {1'b0, w_q};
    assign y_end = y_ext + {1'b0, h_q};

    assign x_addr    = FBUF_ADDR_WIDTH'(x_q);
    assign row_start = FBUF_ADDR_WIDTH'(y_q) * LINE_STRIDE;
    assign next_base = row_base_q + LINE_STRIDE;

`ifdef FBUF_FILL_CLIP_EN
    always_comb begin
        reject = (w_q == '0) || (h_q == '0) || (x_ext >= X_LIMIT) || (y_ext >= Y_LIMIT);
        w_eff  = (x_end > X_LIMIT) ? (COORD_WIDTH'(FB_WIDTH) - x_q) : w_q;
        h_eff  = (y_end > Y_LIMIT) ? (COORD_WIDTH'(FB_HEIGHT) - y_q) : h_q;
    end
`else
    always_comb begin
        reject = (w_q == '0) || (h_q == '0) || (x_end > X_LIMIT) || (y_end > Y_LIMIT);
        w_eff  = w_q;
        h_eff  = h_q;
    end
`endif

    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            state_q <= FILL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL_IDLE:  if (fill_start) state_d = FILL_CHECK;
            FILL_CHECK: state_d = reject ? FILL_IDLE : FILL_RUN;
            FILL_RUN:   if (fill_grant && last_col && last_row) state_d = FILL_IDLE;
            default:    state_d = FILL_IDLE;
        endcase
    end

    // active_q keeps the pixel port closed while reset is asserted and on the release cycle.
    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            active_q     <= 1'b0;
            last_grant_q <= GRANT_FILL;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            w_last_q     <= '0;
            h_last_q     <= '0;
            row_base_q   <= '0;
            cur_q        <= '0;
            fill_done    <= 1'b0;
            fill_err     <= 1'b0;
            fbuf_en_wr   <= 1'b0;
            fbuf_wrea    <= 1'b0;
            fbuf_addr    <= '0;
            fbuf_data    <= '0;
        end else begin
            active_q   <= 1'b1;
            fill_done  <= 1'b0;
            fill_err   <= 1'b0;
            fbuf_en_wr <= 1'b0;
            fbuf_wrea  <= 1'b0;

            if (state_q == FILL_IDLE && fill_start) begin
                x_q     <= fill_x;
                y_q     <= fill_y;
                w_q     <= fill_w;
                h_q     <= fill_h;
                color_q <= fill_color;
            end

            if (state_q == FILL_CHECK) begin
                if (reject) begin
                    fill_err <= 1'b1;
                end else begin
                    w_last_q   <= w_eff - COORD_WIDTH'(1);
                    h_last_q   <= h_eff - COORD_WIDTH'(1);
                    row_base_q <= row_start;
                    cur_q      <= row_start + x_addr;
                    col_q      <= '0;
                    row_q      <= '0;
                end
            end

            // Out-of-range pixels still complete the handshake but never reach the BRAM.
            if (pix_grant) begin
                last_grant_q <= GRANT_PIX;
                if (pix_addr < PIX_LIMIT) begin
                    fbuf_en_wr <= 1'b1;
                    fbuf_wrea  <= 1'b1;
                    fbuf_addr  <= pix_addr;
                    fbuf_data  <= pix_data;
                end
            end

            if (fill_grant) begin
                last_grant_q <= GRANT_FILL;
                fbuf_en_wr   <= 1'b1;
                fbuf_wrea    <= 1'b1;
                fbuf_addr    <= cur_q;
                fbuf_data    <= color_q;
                if (last_col) begin
                    col_q      <= '0;
                    row_q      <= row_q + COORD_WIDTH'(1);
                    row_base_q <= next_base;
                    cur_q      <= next_base + x_addr;
                    if (last_row) fill_done <= 1'b1;
                end else begin
                    col_q <= col_q + COORD_WIDTH'(1);
                    cur_q <= cur_q + FBUF_ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fbuf_write_scheduler.sv
// Self-checking bench for fbuf_write_scheduler: directed vectors, multi-cycle fill sequences, and
// randomized pixel traffic against a rectangle-list reference model (honours FBUF_FILL_CLIP_EN).
`timescale 1ns/1ps
module tb_fbuf_write_scheduler;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int CW = 10;
    localparam int FBW = 640;
    localparam int FBH = 480;
    localparam int PIX_TOTAL = FBW * FBH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [AW-1:0] pix_addr = '0;
    logic [DW-1:0] pix_data = '0;
    logic          fill_start = 1'b0;
    logic [CW-1:0] fill_x = '0, fill_y = '0, fill_w = '0, fill_h = '0;
    logic [DW-1:0] fill_color = '0;
    logic          fill_busy, fill_done, fill_err;
    logic          fbuf_en_wr, fbuf_wrea;
    logic [AW-1:0] fbuf_addr;
    logic [DW-1:0] fbuf_data;

    fbuf_write_scheduler dut (
        .s_axi_ctrl_aclk    (clk),
        .s_axi_ctrl_aresetn (rst_n),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_addr           (pix_addr),
        .pix_data           (pix_data),
        .fill_start         (fill_start),
        .fill_x             (fill_x),
        .fill_y             (fill_y),
        .fill_w             (fill_w),
        .fill_h             (fill_h),
        .fill_color         (fill_color),
        .fill_busy          (fill_busy),
        .fill_done          (fill_done),
        .fill_err           (fill_err),
        .fbuf_en_wr         (fbuf_en_wr),
        .fbuf_wrea          (fbuf_wrea),
        .fbuf_addr          (fbuf_addr),
        .fbuf_data          (fbuf_data)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic exp_wr; } pix_vec_t;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  pix_wr_cnt = 0;
    int  last_hs_cyc = -10;
    bit  rand_stop = 1'b0;
    wr_t fill_q[$];
    wr_t pix_exp[$];
    int  done_cyc[$];
    int  err_cyc[$];
    bit  busy_at_done[$];
    int  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Classifies each BRAM write: a write in the cycle after an in-range pixel handshake is that pixel,
    // anything else belongs to the fill engine.
    always @(negedge clk) begin : monitor
        wr_t w;
        if (!rst_n) begin
            pix_exp.delete();
        end else begin
            if (fbuf_en_wr || fbuf_wrea) check("en_wr_equals_wrea", fbuf_wrea, fbuf_en_wr);
            if (pix_exp.size() > 0 && pix_exp[0].cyc <= cyc) begin
                w = pix_exp.pop_front();
                check("pix_write_issued", fbuf_en_wr, 1'b1);
                if (fbuf_en_wr) begin
                    check("pix_write_addr", fbuf_addr, w.addr);
                    check("pix_write_data", fbuf_data, w.data);
                    pix_wr_cnt++;
                end
            end else if (fbuf_en_wr) begin
                fill_q.push_back('{addr: int'(fbuf_addr), data: int'(fbuf_data), cyc: cyc});
            end
            if (fill_done) begin
                done_cyc.push_back(cyc);
                busy_at_done.push_back(fill_busy);
            end
            if (fill_err) err_cyc.push_back(cyc);
            if (pix_valid && pix_ready) begin
                last_hs_cyc = cyc;
                if (int'(pix_addr) < PIX_TOTAL)
                    pix_exp.push_back('{addr: int'(pix_addr), data: int'(pix_data), cyc: cyc + 1});
            end
        end
    end

    task automatic clear_logs();
        fill_q.delete();
        done_cyc.delete();
        err_cyc.delete();
        busy_at_done.delete();
        pix_wr_cnt = 0;
    endtask

    // Reference: the rectangle as a row-major address list, or rejection.
    function automatic bit model_fill(input int x, input int y, input int w, input int h);
        int we, he;
        bit ok;
        exp_q.delete();
`ifdef FBUF_FILL_CLIP_EN
        ok = (w > 0) && (h > 0) && (x < FBW) && (y < FBH);
        we = (w < FBW - x) ? w : FBW - x;
        he = (h < FBH - y) ? h : FBH - y;
`else
        ok = (w > 0) && (h > 0) && (x + w <= FBW) && (y + h <= FBH);
        we = w;
        he = h;
`endif
        if (ok)
            for (int r = 0; r < he; r++)
                for (int c = 0; c < we; c++)
                    exp_q.push_back((y + r) * FBW + x + c);
        return ok;
    endfunction

    task automatic issue_fill(input int x, input int y, input int w, input int h, input int color,
                              output int s);
        fill_x     = CW'(x);
        fill_y     = CW'(y);
        fill_w     = CW'(w);
        fill_h     = CW'(h);
        fill_color = DW'(color);
        fill_start = 1'b1;
        s = cyc;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic wait_fill_end(input int budget);
        int n = 0;
        while (done_cyc.size() == 0 && err_cyc.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        check("fill_finished_in_budget", 32'(n < budget), 1);
        tick();
        tick();
    endtask

    task automatic compare_fill(input string name, input bit ok, input int s, input int color);
        check({name, "_write_count"}, fill_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < fill_q.size(); i++) begin
            check({name, "_addr"}, fill_q[i].addr, exp_q[i]);
            check({name, "_data"}, fill_q[i].data, color);
        end
        check({name, "_done_count"}, done_cyc.size(), ok ? 1 : 0);
        check({name, "_err_count"}, err_cyc.size(), ok ? 0 : 1);
        if (ok && fill_q.size() > 0) begin
            check({name, "_done_with_last_write"}, done_cyc[0], fill_q[fill_q.size()-1].cyc);
            check({name, "_busy_low_at_done"}, busy_at_done[0], 1'b0);
        end
        if (!ok) check({name, "_err_latency"}, err_cyc[0], s + 2);
    endtask

    task automatic run_fill(input string name, input int x, input int y, input int w, input int h,
                            input int color, input int budget);
        int s;
        bit ok;
        clear_logs();
        ok = model_fill(x, y, w, h);
        issue_fill(x, y, w, h, color, s);
        wait_fill_end(budget);
        compare_fill(name, ok, s, color);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : pix_driver
        wait (rand_stop === 1'b0 && cyc > 0);
    end

    initial begin : main
        pix_vec_t vecs[6];
        logic [AW-1:0] last_addr;
        logic [DW-1:0] last_data;
        int s;
        bit ok;

        vecs[0] = '{addr: 19'd0,      data: 8'h01, exp_wr: 1'b1};
        vecs[1] = '{addr: 19'd307199, data: 8'hA5, exp_wr: 1'b1};
        vecs[2] = '{addr: 19'd307200, data: 8'h3C, exp_wr: 1'b0};
        vecs[3] = '{addr: 19'h7FFFF,  data: 8'hC3, exp_wr: 1'b0};
        vecs[4] = '{addr: 19'd640,    data: 8'h80, exp_wr: 1'b1};
        vecs[5] = '{addr: 19'd12345,  data: 8'h00, exp_wr: 1'b1};

        // Reset with a pixel request pending: everything stays low.
        pix_valid = 1'b1;
        pix_addr  = 19'h00123;
        pix_data  = 8'h5A;
        repeat (2) @(negedge clk);
        check("reset_pix_ready", pix_ready, 0);
        check("reset_fill_busy", fill_busy, 0);
        check("reset_fill_done", fill_done, 0);
        check("reset_fill_err", fill_err, 0);
        check("reset_en_wr", fbuf_en_wr, 0);
        check("reset_wrea", fbuf_wrea, 0);
        check("reset_addr", fbuf_addr, 0);
        check("reset_data", fbuf_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("first_pix_ready", pix_ready, 1);
        tick();
        pix_valid = 1'b0;
        @(negedge clk);
        check("first_pix_en_wr", fbuf_en_wr, 1);
        check("first_pix_addr", fbuf_addr, 32'h123);
        check("first_pix_data", fbuf_data, 32'h5A);
        tick();
        @(negedge clk);
        check("first_pix_one_cycle", fbuf_en_wr, 0);
        check("first_pix_addr_held", fbuf_addr, 32'h123);
        last_addr = 19'h00123;
        last_data = 8'h5A;
        tick();

        // Single-pixel vectors, including the out-of-range boundary.
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1;
            pix_addr  = vecs[i].addr;
            pix_data  = vecs[i].data;
            @(negedge clk);
            check("vec_pix_ready", pix_ready, 1);
            tick();
            pix_valid = 1'b0;
            @(negedge clk);
            if (vecs[i].exp_wr) begin
                last_addr = vecs[i].addr;
                last_data = vecs[i].data;
            end
            check("vec_en_wr", fbuf_en_wr, vecs[i].exp_wr);
            check("vec_addr", fbuf_addr, last_addr);
            check("vec_data", fbuf_data, last_data);
            tick();
        end
        check("vec_no_stray_writes", fill_q.size(), 0);

        // Uncontended fill: six back-to-back writes, first one three cycles after the strobe.
        clear_logs();
        ok = model_fill(10, 2, 3, 2);
        issue_fill(10, 2, 3, 2, 8'hFF, s);
        @(negedge clk);
        check("fill_busy_after_start", fill_busy, 1);
        wait_fill_end(50);
        compare_fill("fill_basic", ok, s, 8'hFF);
        for (int i = 0; i < fill_q.size(); i++)
            check("fill_basic_cycle", fill_q[i].cyc, s + 3 + i);

        // Contended fill: pixel requests from the first RUN cycle; grants alternate, pixel first.
        clear_logs();
        ok = model_fill(10, 2, 3, 2);
        issue_fill(10, 2, 3, 2, 8'hFF, s);
        tick();
        pix_valid = 1'b1;
        pix_addr  = 19'd5;
        pix_data  = 8'h11;
        repeat (12) tick();
        pix_valid = 1'b0;
        wait_fill_end(50);
        compare_fill("fill_contended", ok, s, 8'hFF);
        check("contended_pix_writes", pix_wr_cnt, 6);
        check("contended_done_cycle", done_cyc[0], s + 14);
        for (int i = 0; i < fill_q.size(); i++)
            check("contended_fill_cycle", fill_q[i].cyc, s + 4 + 2 * i);

        // Right-edge overflow (rejected, or clipped to 10 columns), exact-fit corner, zero width.
        run_fill("fill_edge", 630, 0, 20, 2, 8'h42, 100);
        run_fill("fill_exact_corner", 637, 478, 3, 2, 8'h24, 50);
        run_fill("fill_zero_w", 5, 5, 0, 3, 8'h10, 50);

        // fill_start during CHECK and during RUN is ignored.
        clear_logs();
        ok = model_fill(0, 5, 4, 3);
        issue_fill(0, 5, 4, 3, 8'h77, s);
        fill_x = 10'd1; fill_y = 10'd1; fill_w = 10'd1; fill_h = 10'd1; fill_color = 8'h22;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick();
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        wait_fill_end(50);
        compare_fill("fill_restart_ignored", ok, s, 8'h77);

        // Reset in the middle of a full-screen fill aborts it at once.
        issue_fill(0, 0, 640, 480, 8'h99, s);
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        check("abort_en_wr", fbuf_en_wr, 0);
        check("abort_wrea", fbuf_wrea, 0);
        check("abort_busy", fill_busy, 0);
        check("abort_done", fill_done, 0);
        check("abort_addr", fbuf_addr, 0);
        check("abort_data", fbuf_data, 0);
        clear_logs();
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("abort_no_writes", fill_q.size(), 0);
        check("abort_no_done", done_cyc.size(), 0);
        run_fill("fill_after_abort", 2, 3, 2, 2, 8'h44, 50);

        // Randomized fills against concurrent random pixel traffic.
        fork
            begin : rand_pix
                while (!rand_stop) begin
                    tick();
                    if (!pix_valid || last_hs_cyc == cyc - 1) begin
                        pix_valid = ($urandom_range(0, 99) < 40);
                        pix_addr  = ($urandom_range(0, 9) == 0) ? AW'(PIX_TOTAL + $urandom_range(0, 1000))
                                                                 : AW'($urandom_range(0, PIX_TOTAL - 1));
                        pix_data  = DW'($urandom);
                    end
                end
                pix_valid = 1'b0;
            end
        join_none
        for (int k = 0; k < 25; k++) begin
            int rx, ry, rw, rh, rc;
            rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(620, 645)) : int'($urandom_range(0, 600));
            ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 485)) : int'($urandom_range(0, 460));
            rw = $urandom_range(0, 12);
            rh = $urandom_range(0, 4);
            rc = $urandom_range(0, 255);
            run_fill("rand_fill", rx, ry, rw, rh, rc, 400);
        end
        rand_stop = 1'b1;
        repeat (5) tick();
        check("rand_pix_all_written", pix_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
